conv2d_stream_engine: RTL and testbench
=======================================

// Module: conv2d_stream_engine
// PURPOSE
//  Parametrised KxK 2D convolution engine: valid-mode conv of an IMG_W x IMG_H source image in BRAM
//  to an (IMG_W-K+1) x (IMG_H-K+1) destination BRAM. Run-time loadable signed kernel, arithmetic-shift
//  normalisation, start/busy/done handshake, latency-aware BRAM reads, and result readback port.
//  Sits between source image BRAM and result BRAM in the image processing datapath.
// PARAMETERS
//  IMG_W   20  source image width, pixels
//  IMG_H   20  source image height, pixels
//  K       3   kernel size (K x K), 2..7
//  DW      8   pixel width, unsigned
//  CW      4   coefficient width, signed two's complement
//  SHIFT   3   arithmetic right shift applied to accumulator before output
//  SRC_AW  15  source address width;  DST_AW 14  destination address width
//  RD_LAT  1   BRAM read latency in clk cycles (1 or 2), same for both BRAMs
// PORTS
//  clk       in   1              clock, all logic rising-edge
//  rst       in   1              reset, synchronous, active-high
//  start     in   1              pulse; begins a frame when IDLE or DONE
//  busy      out  1              high while frame in progress
//  done      out  1              high in DONE, held until start or rst
//  coef_we   in   1              kernel coefficient write strobe
//  coef_idx  in   $clog2(K*K)    coefficient index, row-major (r*K+c)
//  coef_din  in   CW             signed coefficient value
//  src_addr  out  SRC_AW         source BRAM read address
//  src_dout  in   DW             source BRAM read data, valid RD_LAT cycles after address
//  dst_we    out  1              destination BRAM write enable
//  dst_addr  out  DST_AW         destination BRAM address (write, or readback read)
//  dst_din   out  DW             destination BRAM write data
//  dst_dout  in   DW             destination BRAM read data
//  rd_en     in   1              readback request (honoured only in IDLE/DONE)
//  rd_addr   in   DST_AW         readback address
//  rd_data   out  DW             readback data;  rd_valid out 1  high for one cycle, RD_LAT after rd_en
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, done=0, dst_we=0, rd_valid=0, src_addr=0, dst_addr=0, dst_din=0,
//    rd_data=0; all K*K coefficients reset to +1 (box filter). rst mid-frame: IDLE next edge, no further writes.
//  - OW=IMG_W-K+1, OH=IMG_H-K+1; output (ox,oy) -> dst_addr oy*OW+ox; taps src (oy+r)*IMG_W+(ox+c).
//  - FSM: IDLE -start-> ACC; ACC issues K*K reads, one per cycle, row-major, then waits RD_LAT
//    cycles for last data -> WR; WR one cycle dst_we=1 -> ACC (next pixel) or DONE after pixel OW*OH-1.
//    DONE -start-> ACC (new frame, acc/counters cleared). busy=1 in ACC/WR, registered from next edge.
//  - Per output pixel: K*K+RD_LAT+1 cycles; frame = OW*OH*(K*K+RD_LAT+1) cycles after start edge.
//  - Accumulator signed, width DW+CW+$clog2(K*K)+1, no overflow possible; pixel zero-extended before multiply;
//    acc cleared at start of each output pixel. result = acc >>> SHIFT (arithmetic, floor).
//  - start while busy ignored; coef_we while busy ignored (kernel frozen for whole frame);
//    coef_we accepted in IDLE/DONE, takes effect next cycle.
//  - Readback: rd_en in IDLE/DONE drives dst_addr=rd_addr; rd_data=dst_dout and rd_valid=1 exactly RD_LAT
//    cycles later; rd_en while busy ignored, rd_valid stays 0. dst_we never asserted outside WR.
//  - start and rd_en same cycle in IDLE/DONE: start wins, readback dropped.
// CONFIGURATION
//  CONV_SAT_EN defined: result clamped to [0, 2^DW-1] (negative -> 0, overflow -> 2^DW-1).
//  CONV_SAT_EN undefined: dst_din = result[DW-1:0] (two's-complement wrap).
// TESTING
//  1. Assert rst 2 cycles -> all outputs 0, busy=0, done=0; readback before start returns stale BRAM, no write.
//  2. Defaults, constant image 8, box kernel, start -> 324 writes all 72>>>3=9; done after 324*11 cycles.
//  3. Load kernel all 0 except centre=-1, image 8 -> SAT: all 0; no SAT: (-8>>>3)=-1 -> 0xFF.
//  4. After test 2: rd_en rd_addr=0 and 323 -> rd_valid RD_LAT later, rd_data=9; rd_en during busy -> no rd_valid.
//  5. rst asserted during output pixel 10 -> no dst_we after that edge, IDLE; restart -> full 324-pixel frame.
//  6. start and coef_we pulses while busy -> ignored: frame length unchanged, results use pre-start kernel.

Source files
------------

// File: rtl/conv2d_stream_engine_if.sv
// conv2d_stream_engine_if: control, kernel-load, BRAM and readback signals of the convolution engine
interface conv2d_stream_engine_if #(
  parameter int K      = 3,
  parameter int DW     = 8,
  parameter int CW     = 4,
  parameter int SRC_AW = 15,
  parameter int DST_AW = 14
);
  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     coef_we;
  logic [$clog2(K*K)-1:0]   coef_idx;
  logic signed [CW-1:0]     coef_din;
  logic [SRC_AW-1:0]        src_addr;
  logic [DW-1:0]            src_dout;
  logic                     dst_we;
  logic [DST_AW-1:0]        dst_addr;
  logic [DW-1:0]            dst_din;
  logic [DW-1:0]            dst_dout;
  logic                     rd_en;
  logic [DST_AW-1:0]        rd_addr;
  logic [DW-1:0]            rd_data;
  logic                     rd_valid;
  modport master (
    output start, coef_we, coef_idx, coef_din, src_dout, dst_dout, rd_en, rd_addr,
    input  busy, done, src_addr, dst_we, dst_addr, dst_din, rd_data, rd_valid
  );
  modport slave (
    input  start, coef_we, coef_idx, coef_din, src_dout, dst_dout, rd_en, rd_addr,
    output busy, done, src_addr, dst_we, dst_addr, dst_din, rd_data, rd_valid
  );
endinterface

// File: rtl/conv2d_stream_engine.sv
// conv2d_stream_engine: KxK valid-mode 2D convolution from source BRAM to destination BRAM.
// Define CONV_SAT_EN to clamp results to [0, 2^DW-1] instead of wrapping.
module conv2d_stream_engine #(
  parameter int IMG_W  = 20,
  parameter int IMG_H  = 20,
  parameter int K      = 3,
  parameter int DW     = 8,
  parameter int CW     = 4,
  parameter int SHIFT  = 3,
  parameter int SRC_AW = 15,
  parameter int DST_AW = 14,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rst,
  conv2d_stream_engine_if.slave bus
);
  localparam int OW  = IMG_W - K + 1;
  localparam int OH  = IMG_H - K + 1;
  localparam int NT  = K * K;
  localparam int CIW = $clog2(NT);
  localparam int AW  = DW + CW + CIW + 1;
  localparam int TW  = $clog2(NT + RD_LAT + 1);
  typedef enum logic [1:0] {IDLE, ACC, WR, DONE} state_t;
  state_t r_state, w_next;
  logic signed [CW-1:0] r_coef [NT];
  logic signed [CW-1:0] w_c;
  logic signed [AW-1:0] r_acc, w_px, w_cf;
  logic [TW-1:0]        r_tap;
  logic [CIW-1:0]       r_c, w_cidx;
  logic [SRC_AW-1:0]    r_off, r_base;
  logic [DST_AW-1:0]    r_ox, r_out;
  logic [RD_LAT-1:0]    r_rv;
  logic w_idle, w_start, w_last_tap, w_last_px, w_rd, w_eol, w_eor;
  assign w_idle     = r_state == IDLE || r_state == DONE;
  assign w_start    = w_idle && bus.start;
  assign w_rd       = w_idle && bus.rd_en && !bus.start;
  assign w_last_tap = r_tap == TW'(NT + RD_LAT - 1);
  assign w_last_px  = r_out == DST_AW'(OW * OH - 1);
  assign w_eol      = r_c == CIW'(K - 1);
  assign w_eor      = r_ox == DST_AW'(OW - 1);
  // data for tap t returns RD_LAT cycles after issue, so the tap counter doubles as the coefficient index
  assign w_cidx     = CIW'(r_tap - TW'(RD_LAT));
  assign w_c        = r_coef[w_cidx];
  assign w_cf       = {{(AW-CW){w_c[CW-1]}}, w_c};
  assign w_px       = {{(AW-DW){1'b0}}, bus.src_dout};
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = w_start ? ACC :
             (r_state == ACC && w_last_tap) ? WR :
             r_state == WR ? (w_last_px ? DONE : ACC) : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NT; i++) r_coef[i] <= CW'(1);
      r_acc  <= '0;
      r_tap  <= '0;
      r_c    <= '0;
      r_off  <= '0;
      r_base <= '0;
      r_ox   <= '0;
      r_out  <= '0;
      r_rv   <= '0;
    end else begin
      if (bus.coef_we && w_idle && int'(bus.coef_idx) < NT) r_coef[bus.coef_idx] <= bus.coef_din;
      r_rv <= RD_LAT'({r_rv, w_rd});
      if (w_start || r_state == WR) begin
        r_tap <= '0;
        r_c   <= '0;
        r_off <= '0;
        r_acc <= '0;
      end else if (r_state == ACC) begin
        r_tap <= r_tap + TW'(1);
        if (r_tap < TW'(NT)) begin
          r_c   <= w_eol ? '0 : r_c + CIW'(1);
          r_off <= r_off + (w_eol ? SRC_AW'(IMG_W - K + 1) : SRC_AW'(1));
        end
        if (r_tap >= TW'(RD_LAT)) r_acc <= r_acc + w_px * w_cf;
      end
      if (w_start) begin
        r_ox   <= '0;
        r_out  <= '0;
        r_base <= '0;
      end else if (r_state == WR && !w_last_px) begin
        r_out  <= r_out + DST_AW'(1);
        r_ox   <= w_eor ? '0 : r_ox + DST_AW'(1);
        r_base <= r_base + (w_eor ? SRC_AW'(K) : SRC_AW'(1));
      end
    end
  end
  assign bus.busy     = r_state == ACC || r_state == WR;
  assign bus.done     = r_state == DONE;
  assign bus.src_addr = r_base + r_off;
  assign bus.dst_we   = r_state == WR;
  assign bus.dst_addr = r_state == WR ? r_out : w_rd ? bus.rd_addr : '0;
  assign bus.rd_valid = r_rv[RD_LAT-1];
  assign bus.rd_data  = r_rv[RD_LAT-1] ? bus.dst_dout : '0;
`ifdef CONV_SAT_EN
  logic signed [AW-1:0] w_res;
  assign w_res       = r_acc >>> SHIFT;
  assign bus.dst_din = r_state != WR ? '0 : w_res[AW-1] ? '0 : |w_res[AW-2:DW] ? '1 : w_res[DW-1:0];
`else
  logic [DW-1:0] w_res;
  assign w_res       = DW'(r_acc >>> SHIFT);
  assign bus.dst_din = r_state == WR ? w_res : '0;
`endif
endmodule

// File: tb/tb_conv2d_stream_engine.sv
// tb_conv2d_stream_engine: randomized scoreboard bench comparing BRAM writes and readbacks
// against a direct sum-of-products convolution model.
module tb_conv2d_stream_engine;
  localparam int IW = 20, K = 3, OW = 18, NPX = 324, FRAME = NPX * 11;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  conv2d_stream_engine_if bus ();
  conv2d_stream_engine dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {int addr; int data;} wr_t;
  typedef struct {int data; int due;} rd_t;
  wr_t wr_q[$];
  rd_t rd_q[$];
  logic [7:0] src_mem [512];
  logic [7:0] dst_mem [512];
  int img [400];
  int kern [9];
  int n_chk = 0, n_fail = 0, n_wr = 0, n_rv = 0, cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.src_dout <= src_mem[bus.src_addr[8:0]];
    bus.dst_dout <= dst_mem[bus.dst_addr[8:0]];
    if (rst) for (int i = 0; i < 512; i++) dst_mem[i] <= 8'(i * 7 + 3);
    else if (bus.dst_we) dst_mem[bus.dst_addr[8:0]] <= bus.dst_din;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic int model_px(input int a);
    int ox = a % OW, oy = a / OW, s = 0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) s += img[(oy + r) * IW + ox + c] * kern[r * K + c];
    s = s >>> 3;
`ifdef CONV_SAT_EN
    return s < 0 ? 0 : s > 255 ? 255 : s;
`else
    return s & 255;
`endif
  endfunction
  always @(negedge clk) begin
    wr_t e;
    if (bus.dst_we === 1'b1) begin
      n_wr++;
      if (wr_q.size() == 0) check("unexpected_write_addr", 32'(bus.dst_addr), 32'hFFFF_FFFF);
      else begin
        e = wr_q.pop_front();
        check("wr_addr", 32'(bus.dst_addr), e.addr);
        check("wr_data", 32'(bus.dst_din), e.data);
      end
    end
  end
  always @(negedge clk) begin
    rd_t e;
    if (bus.rd_valid === 1'b1) begin
      n_rv++;
      if (rd_q.size() == 0) check("unexpected_rd_valid", 32'(bus.rd_valid), 0);
      else begin
        e = rd_q.pop_front();
        check("rd_data", 32'(bus.rd_data), e.data);
        check("rd_latency", cyc, e.due);
      end
    end
  end
  task automatic readback(input int a, input int exp);
    @(negedge clk);
    bus.rd_en = 1;
    bus.rd_addr = 14'(a);
    rd_q.push_back('{exp, cyc + 1});
    @(negedge clk);
    bus.rd_en = 0;
    @(negedge clk);
  endtask
  task automatic load_kern;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.coef_we = 1;
      bus.coef_idx = 4'(i);
      bus.coef_din = 4'(kern[i]);
    end
    @(negedge clk);
    bus.coef_we = 0;
  endtask
  task automatic prep_frame;
    for (int i = 0; i < 400; i++) src_mem[i] = img[i][7:0];
    for (int a = 0; a < NPX; a++) wr_q.push_back('{a, model_px(a)});
    n_wr = 0;
    @(negedge clk);
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
  endtask
  // disturb pulses start, coef_we and rd_en mid-frame; all must be ignored
  task automatic run_frame(input bit disturb);
    int cycles = 0;
    int rv0 = n_rv;
    prep_frame();
    while (bus.done !== 1'b1 && cycles < FRAME + 100) begin
      if (disturb) begin
        bus.start    = cycles == 20;
        bus.coef_we  = cycles == 20;
        bus.rd_en    = cycles == 20;
        bus.coef_idx = 0;
        bus.coef_din = kern[0] == 7 ? 4'h8 : 4'h7;
        bus.rd_addr  = 0;
      end
      @(negedge clk);
      cycles++;
    end
    check("frame_cycles", cycles, FRAME);
    check("frame_writes", n_wr, NPX);
    check("wr_q_left", wr_q.size(), 0);
    check("busy_rd_valids", n_rv, rv0);
    wr_q.delete();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation timed out at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    int t;
    bus.start = 0; bus.coef_we = 0; bus.coef_idx = 0; bus.coef_din = 0;
    bus.rd_en = 0; bus.rd_addr = 0;
    for (int i = 0; i < 400; i++) img[i] = 8;
    for (int i = 0; i < 9; i++) kern[i] = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_dst_we", 32'(bus.dst_we), 0);
    check("rst_rd_valid", 32'(bus.rd_valid), 0);
    check("rst_src_addr", 32'(bus.src_addr), 0);
    check("rst_dst_addr", 32'(bus.dst_addr), 0);
    check("rst_dst_din", 32'(bus.dst_din), 0);
    check("rst_rd_data", 32'(bus.rd_data), 0);
    rst = 0;
    readback(0, 3);
    readback(5, 38);
    check("idle_writes", n_wr, 0);
    run_frame(0);
    check("done_held", 32'(bus.done), 1);
    readback(0, model_px(0));
    readback(323, model_px(323));
    for (int i = 0; i < 9; i++) kern[i] = 0;
    kern[4] = -1;
    load_kern();
    run_frame(0);
    for (int i = 0; i < 400; i++) img[i] = int'($urandom_range(255));
    for (int i = 0; i < 9; i++) kern[i] = int'($urandom_range(15)) - 8;
    load_kern();
    run_frame(0);
    for (int i = 0; i < 3; i++) begin
      t = int'($urandom_range(NPX - 1));
      readback(t, model_px(t));
    end
    for (int i = 0; i < 400; i++) img[i] = int'($urandom_range(255));
    run_frame(1);
    prep_frame();
    t = 0;
    while (n_wr < 10 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    check("pre_reset_writes", n_wr, 10);
    @(negedge clk);
    rst = 1;
    wr_q.delete();
    @(negedge clk);
    rst = 0;
    check("reset_busy", 32'(bus.busy), 0);
    repeat (30) @(negedge clk);
    check("post_reset_writes", n_wr, 10);
    check("post_reset_done", 32'(bus.done), 0);
    for (int i = 0; i < 9; i++) kern[i] = 1;
    for (int i = 0; i < 400; i++) img[i] = int'($urandom_range(255));
    run_frame(0);
    check("rd_q_left", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
